gcd_engine: RTL and testbench

//   Iterative subtract-based GCD datapath and controller. Sits directly downstream of the
//   16-bit magnitude comparator: it consumes lt/gt/eq from its own comparator instance and

---
 rtl/gcd_pkg.sv | 10 +
 rtl/gcd_cmp.sv | 14 +
 rtl/gcd_engine.sv | 87 ++++++++
 tb/tb_gcd_engine.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared width and FSM state encoding for the subtract-based GCD engine.
package gcd_pkg;
  localparam int GCD_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_t;
endpackage

// File: rtl/gcd_cmp.sv
// Unsigned magnitude comparator steering the GCD subtraction each CALC cycle.
module gcd_cmp #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             gt,
  output logic             eq
);
  assign lt = (a < b);
  assign gt = (a > b);
  assign eq = (a == b);
endmodule

// File: rtl/gcd_engine.sv
// Iterative subtract-based GCD with valid/ready in/out handshakes.
// Optional iteration counter port enabled by defining GCD_ITER_COUNT_EN.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef GCD_ITER_COUNT_EN
  output logic [WIDTH-1:0] iter_cnt,
`endif
  output logic [WIDTH-1:0] out_gcd
);
  gcd_state_t       state;
  logic [WIDTH-1:0] reg_a, reg_b;
  logic             lt, gt, eq;

  gcd_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a (reg_a),
    .b (reg_b),
    .lt(lt),
    .gt(gt),
    .eq(eq)
  );

  // in_ready/out_valid are registered alongside state so they track it exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      reg_a     <= '0;
      reg_b     <= '0;
      out_gcd   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          reg_a    <= in_a;
          reg_b    <= in_b;
          state    <= CALC;
          in_ready <= 1'b0;
        end
        CALC: begin
          if (reg_a == '0 || reg_b == '0) begin
            out_gcd   <= reg_a | reg_b;
            state     <= DONE;
            out_valid <= 1'b1;
          end else if (eq) begin
            out_gcd   <= reg_a;
            state     <= DONE;
            out_valid <= 1'b1;
          end else if (gt) begin
            reg_a <= reg_a - reg_b;
          end else if (lt) begin
            reg_b <= reg_b - reg_a;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef GCD_ITER_COUNT_EN
  // Counts every CALC cycle, including the terminating one; held through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        iter_cnt <= '0;
    else if (state == IDLE && in_valid) iter_cnt <= '0;
    else if (state == CALC)             iter_cnt <= iter_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_gcd_engine.sv
// Directed plus randomized bench for gcd_engine against a Euclid-based reference.
module tb_gcd_engine;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_gcd;
`ifdef GCD_ITER_COUNT_EN
  logic [W-1:0] iter_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gcd_engine #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef GCD_ITER_COUNT_EN
    .iter_cnt (iter_cnt),
`endif
    .out_gcd  (out_gcd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: gcd by Euclid's remainders; CALC cycle count is the number of
  // subtractions the repeated-subtraction form would do, plus the final cycle.
  function automatic void ref_gcd(input int a, input int b, output int g, output int n);
    n = 0;
    while (a != 0 && b != 0 && a != b) begin
      if (a > b) begin
        if (a % b == 0) begin n += a / b - 1; a = b; end
        else begin n += a / b; a = a % b; end
      end else begin
        if (b % a == 0) begin n += b / a - 1; b = a; end
        else begin n += b / a; b = b % a; end
      end
    end
    g = (a == 0 || b == 0) ? (a | b) : a;
    n += 1;
  endfunction

  // One operation; bp_cycles > 0 holds out_ready low that long in DONE.
  task automatic run_op(input int a, input int b, input int bp_cycles, input string tag);
    int g, n, cyc;
    ref_gcd(a, b, g, n);
    @(negedge clk);
    check({tag, ".in_ready"}, in_ready, 1);
    out_ready = (bp_cycles == 0);
    in_a = a[W-1:0]; in_b = b[W-1:0]; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < n + 5) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".gcd"}, out_gcd, g);
`ifdef GCD_ITER_COUNT_EN
    check({tag, ".iter"}, iter_cnt, n);
`endif
    if (bp_cycles > 0) begin
      in_valid = 1'b1; in_a = 16'd5; in_b = 16'd10;
      for (int i = 0; i < bp_cycles; i++) begin
        @(posedge clk); #1;
        check({tag, ".bp_gcd"}, out_gcd, g);
        check({tag, ".bp_in_ready"}, in_ready, 0);
        check({tag, ".bp_out_valid"}, out_valid, 1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, ".idle_in_ready"}, in_ready, 1);
    check({tag, ".idle_out_valid"}, out_valid, 0);
  endtask

  initial begin
    int ra, rb, g;
    int cyc;
    // reset state
    #12;
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.out_gcd", out_gcd, 0);
`ifdef GCD_ITER_COUNT_EN
    check("rst.iter", iter_cnt, 0);
`endif
    @(negedge clk); rst_n = 1'b1;

    run_op(48, 18, 0, "t48_18");
    run_op(17, 13, 0, "t17_13");
    run_op(0, 7, 0, "t0_7");
    run_op(7, 0, 0, "t7_0");
    run_op(0, 0, 0, "t0_0");
    run_op(9, 9, 0, "t9_9");
    run_op(65535, 65535, 0, "tmax_max");
    run_op(48, 18, 10, "bp");

    // reset in the middle of a long computation
    @(negedge clk);
    in_a = 16'hFFFF; in_b = 16'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (99) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst.in_ready", in_ready, 1);
    check("mid_rst.out_valid", out_valid, 0);
`ifdef GCD_ITER_COUNT_EN
    check("mid_rst.iter", iter_cnt, 0);
`endif
    @(posedge clk); #2 rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) cyc++;
    end
    check("mid_rst.quiet", cyc, 0);

    // back-to-back with in_valid held high throughout
    @(negedge clk);
    in_a = 16'd12; in_b = 16'd18; in_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b.accept1", in_ready, 0);
    in_a = 16'd35; in_b = 16'd14;
    cyc = 0;
    while (!out_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    check("b2b.valid1", out_valid, 1);
    check("b2b.gcd1", out_gcd, 6);
    @(posedge clk); #1;
    check("b2b.idle", in_ready, 1);
    @(posedge clk); #1;
    check("b2b.accept2", in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    in_valid = 1'b0;
    check("b2b.valid2", out_valid, 1);
    check("b2b.gcd2", out_gcd, 7);
    @(posedge clk); #1;

    // randomized operands, kept small so iteration counts stay bounded
    for (int i = 0; i < 12; i++) begin
      ra = $urandom_range(0, 1023);
      rb = $urandom_range(0, 1023);
      if (i % 3 == 0) begin
        g = $urandom_range(1, 60);
        ra = g * $urandom_range(1, 1000);
        rb = g * $urandom_range(1, 1000);
      end
      run_op(ra, rb, (i == 5) ? 3 : 0, $sformatf("rnd%0d_%0d_%0d", i, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
